// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//
// Conditions a raw asynchronous 1-bit input (push-button, switch, external
// strobe) into a clean synchronous level plus single-cycle edge pulses.
// Processing chain: synchronizer flops -> debounce counter/FSM -> registered
// outputs. level is meant to feed a downstream dff's d; rise/fall feed its en.
//
// Parameters:
//   SYNC_STAGES     - synchronizer depth on din (2..4)
//   DEBOUNCE_CYCLES - consecutive enabled mismatching samples needed to accept
//                     a new level (1..2**CNT_W)
//   CNT_W           - debounce counter width (1..32)
//
// Ports:
//   clk   - single clock, all state changes on posedge
//   rst   - asynchronous active-low reset; clears all state immediately
//   din   - raw asynchronous input
//   en    - sample enable; when low the debounce state and level freeze
//   level - debounced, registered level
//   rise  - one-cycle pulse in the first cycle level shows 1 after a 0
//   fall  - one-cycle pulse in the first cycle level shows 0 after a 1
//   busy  - high while a candidate transition is being counted (cnt != 0)
// -----------------------------------------------------------------------------
module debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // -------------------------------------------------------------------------
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("debounce_edge: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("debounce_edge: CNT_W=%0d outside 1..32", CNT_W);
        end
        if (DEBOUNCE_CYCLES < 1 ||
            longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_debounce
            $error("debounce_edge: DEBOUNCE_CYCLES=%0d outside 1..2**CNT_W",
                   DEBOUNCE_CYCLES);
        end
    endgenerate

    // Terminal count: the sample that reaches this value while still
    // mismatching is the one that commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronizer: shifts every edge regardless of en
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debounce FSM state register
    // -------------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        if (en) begin
            unique case (state)
                IDLE: begin
                    if (s != level) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // Single-sample debounce: accept immediately.
                            level_nxt = s;
                            rise_nxt  = s;
                            fall_nxt  = ~s;
                        end else begin
                            cnt_nxt   = CNT_ONE;
                            state_nxt = COUNT;
                        end
                    end
                end

                COUNT: begin
                    if (s == level) begin
                        // Glitch rejected before reaching the terminal count.
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        level_nxt = s;
                        rise_nxt  = s;
                        fall_nxt  = ~s;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end

                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: tb/tb_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge
//
// Bench for debounce_edge. Two instances run side by side on shared stimulus:
// dut_a with default parameters (2 sync stages, 4-sample debounce) and dut_b
// with 3 sync stages and single-sample debounce. A behavioural model tracks,
// per instance, a delayed copy of din and the length of the current run of
// enabled samples that disagree with the accepted level; all outputs are
// compared against it on every falling clock edge. Directed sections pin the
// model with literal expectations, then a randomized section exercises runs,
// enable gaps and occasional resets.
// -----------------------------------------------------------------------------
module tb_debounce_edge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic en  = 1'b1;

    logic a_level, a_rise, a_fall, a_busy;
    logic b_level, b_rise, b_fall, b_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_edge #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut_a (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .level(a_level),
        .rise (a_rise),
        .fall (a_fall),
        .busy (a_busy)
    );

    debounce_edge #(
        .SYNC_STAGES    (3),
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (4)
    ) dut_b (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .level(b_level),
        .rise (b_rise),
        .fall (b_fall),
        .busy (b_busy)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: index 0 = dut_a, index 1 = dut_b
    // -------------------------------------------------------------------------
    int  m_ss [2] = '{2, 3};
    int  m_dc [2] = '{4, 1};
    bit  m_hist  [2][4];
    int  m_run   [2];
    bit  m_level [2];
    bit  m_rise  [2];
    bit  m_fall  [2];

    always @(posedge clk or negedge rst) begin : model
        bit s;
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 4; i++) m_hist[m][i] = 1'b0;
                m_run[m]   = 0;
                m_level[m] = 1'b0;
                m_rise[m]  = 1'b0;
                m_fall[m]  = 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                // din as it was SYNC_STAGES edges ago
                s = m_hist[m][m_ss[m]-1];
                for (int i = 3; i > 0; i--) m_hist[m][i] = m_hist[m][i-1];
                m_hist[m][0] = din;
                m_rise[m] = 1'b0;
                m_fall[m] = 1'b0;
                if (en) begin
                    if (s != m_level[m]) begin
                        m_run[m]++;
                        if (m_run[m] == m_dc[m]) begin
                            m_level[m] = s;
                            m_rise[m]  = s;
                            m_fall[m]  = !s;
                            m_run[m]   = 0;
                        end
                    end else begin
                        m_run[m] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("a_level", a_level, m_level[0]);
        chk("a_rise",  a_rise,  m_rise[0]);
        chk("a_fall",  a_fall,  m_fall[0]);
        chk("a_busy",  a_busy,  m_run[0] != 0);
        chk("b_level", b_level, m_level[1]);
        chk("b_rise",  b_rise,  m_rise[1]);
        chk("b_fall",  b_fall,  m_fall[1]);
        chk("b_busy",  b_busy,  m_run[1] != 0);
    end

    // Advance n rising edges, then settle 3 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_level"}, a_level, 1'b0);
        chk({tag, "_a_rise"},  a_rise,  1'b0);
        chk({tag, "_a_fall"},  a_fall,  1'b0);
        chk({tag, "_a_busy"},  a_busy,  1'b0);
        chk({tag, "_b_level"}, b_level, 1'b0);
        chk({tag, "_b_rise"},  b_rise,  1'b0);
        chk({tag, "_b_fall"},  b_fall,  1'b0);
        chk({tag, "_b_busy"},  b_busy,  1'b0);
    endtask

    logic [4:0] tog;

    initial begin
        // Asynchronous reset with din high, before any clock edge.
        din = 1'b1;
        #2 rst = 1'b0;
        #1 chk_all_zero("rst_async");
        step(2);
        rst = 1'b1;

        // Post-reset rise: dut_b on edge 4, dut_a on edge 6.
        step(3);
        chk("pr3_a_level", a_level, 1'b0);
        chk("pr3_a_busy",  a_busy,  1'b1);
        chk("pr3_b_level", b_level, 1'b0);
        step(1);
        chk("pr4_b_level", b_level, 1'b1);
        chk("pr4_b_rise",  b_rise,  1'b1);
        chk("pr4_a_level", a_level, 1'b0);
        step(1);
        chk("pr5_b_rise",  b_rise,  1'b0);
        chk("pr5_a_level", a_level, 1'b0);
        chk("pr5_a_busy",  a_busy,  1'b1);
        step(1);
        chk("pr6_a_level", a_level, 1'b1);
        chk("pr6_a_rise",  a_rise,  1'b1);
        chk("pr6_a_fall",  a_fall,  1'b0);
        chk("pr6_a_busy",  a_busy,  1'b0);
        step(1);
        chk("pr7_a_rise",  a_rise,  1'b0);
        chk("pr7_a_level", a_level, 1'b1);

        // Falling transition on dut_a: level drops on the 6th edge.
        din = 1'b0;
        step(5);
        chk("fl5_a_level", a_level, 1'b1);
        step(1);
        chk("fl6_a_level", a_level, 1'b0);
        chk("fl6_a_fall",  a_fall,  1'b1);
        chk("fl6_a_rise",  a_rise,  1'b0);
        step(1);
        chk("fl7_a_fall",  a_fall,  1'b0);
        step(2);

        // Three-cycle glitch: counted but rejected by dut_a.
        din = 1'b1;
        step(3);
        din = 1'b0;
        chk("gl3_a_busy",  a_busy,  1'b1);
        step(2);
        chk("gl5_a_busy",  a_busy,  1'b1);
        chk("gl5_a_level", a_level, 1'b0);
        step(1);
        chk("gl6_a_busy",  a_busy,  1'b0);
        chk("gl6_a_level", a_level, 1'b0);
        chk("gl6_a_rise",  a_rise,  1'b0);
        step(4);

        // One-cycle din pulse: accepted by dut_b as rise then fall.
        din = 1'b1;
        step(1);
        din = 1'b0;
        step(3);
        chk("p4_b_level", b_level, 1'b1);
        chk("p4_b_rise",  b_rise,  1'b1);
        step(1);
        chk("p5_b_level", b_level, 1'b0);
        chk("p5_b_fall",  b_fall,  1'b1);
        chk("p5_b_rise",  b_rise,  1'b0);
        step(4);

        // Enable freeze mid-count, din toggling, then resume.
        din = 1'b1;
        step(4);
        chk("en4_a_busy", a_busy, 1'b1);
        en  = 1'b0;
        tog = 5'b11010;
        for (int i = 0; i < 5; i++) begin
            din = tog[i];
            step(1);
            chk("enoff_a_busy",  a_busy,  1'b1);
            chk("enoff_a_level", a_level, 1'b0);
            chk("enoff_a_rise",  a_rise,  1'b0);
        end
        en = 1'b1;
        step(1);
        chk("enres1_a_busy",  a_busy,  1'b1);
        chk("enres1_a_level", a_level, 1'b0);
        step(1);
        chk("enres2_a_level", a_level, 1'b1);
        chk("enres2_a_rise",  a_rise,  1'b1);

        // Reset while rise is high.
        rst = 1'b0;
        #1 chk_all_zero("rst_pulse");
        step(1);
        rst = 1'b1;

        // Reset mid-count.
        step(3);
        chk("rc3_a_busy", a_busy, 1'b1);
        rst = 1'b0;
        #1 chk_all_zero("rst_count");
        step(1);
        rst = 1'b1;

        // Randomized runs with enable gaps and occasional resets.
        for (int k = 0; k < 400; k++) begin
            int hold;
            hold = $urandom_range(1, 7);
            din  = 1'($urandom_range(0, 1));
            for (int c = 0; c < hold; c++) begin
                en = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 199) == 0) begin
                    rst = 1'b0;
                    step(1);
                    rst = 1'b1;
                end
                step(1);
            end
        end

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
